dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//   Data-memory responder (slave end) of the core's load/store port, replacing the zero-latency
//   combinational data memory with a handshaked, multi-cycle target.
//   Accepts one request at a time and waits a programmable number of cycles.
//   Performs funct3-sized stores with byte lanes. Returns sign/zero-extended load data with an
//   error flag for misaligned or out-of-range accesses.
// PARAMETERS
//   ADDR_W       20    byte-address width (matches 20-bit PC/data address space)
//   DEPTH_WORDS  1024  number of 32-bit words backed; word index = addr[ADDR_W-1:2]
//   WAIT_CYCLES  2     extra wait-state cycles between accept and response (0 allowed)
// PORTS
//   clk         in   1       clock, all state updates on rising edge
//   reset       in   1       synchronous, active-high reset
//   req_valid   in   1       request present
//   req_ready   out  1       responder can accept request this cycle
//   req_write   in   1       1 = store, 0 = load
//   req_funct   in   3       RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   req_addr    in   ADDR_W  byte address
//   req_wdata   in   32      store data, value right-justified (bits [7:0]/[15:0]/[31:0])
//   rsp_valid   out  1       response present
//   rsp_ready   in   1       requester takes response this cycle
//   rsp_rdata   out  32      extended load data; 0 for stores and errors
//   rsp_err     out  1       1 = misaligned / out-of-range / illegal funct3
// BEHAVIOUR
//   Reset: state=IDLE, req_ready=0 in the reset cycle and 1 the cycle after.
//     rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0. Memory array is NOT cleared.
//   FSM IDLE -> WAIT -> RESP -> IDLE:
//     IDLE: req_ready=1. On req_valid&&req_ready, capture write/funct/addr/wdata.
//       Load cnt=WAIT_CYCLES and go to WAIT.
//     WAIT: req_ready=0. If cnt!=0, decrement. If cnt==0, perform the access and go to RESP.
//       The access is a store commit, or an array read plus extension into rsp_rdata.
//     RESP: rsp_valid=1; rsp_rdata/rsp_err held stable until rsp_ready.
//       On rsp_ready go to IDLE and clear rsp_valid. req_ready rises next cycle.
//       No accept happens in the same cycle as the response handshake.
//   Latency: rsp_valid first high exactly WAIT_CYCLES+1 cycles after the accepting edge.
//     Minimum request-to-request spacing is WAIT_CYCLES+3 cycles when rsp_ready is held high.
//   Alignment: H/HU need addr[0]=0. W needs addr[1:0]=00. B/BU are always aligned.
//   Range: error if addr[ADDR_W-1:2] >= DEPTH_WORDS.
//   funct3: any value other than the five listed is an error. For stores, only 000/001/010
//     are legal; 100/101 on a store is an error.
//   Error: no array write, rsp_rdata=0, rsp_err=1. Error still takes the full wait latency.
//   Stores: byte lanes selected by addr[1:0]. SB writes lane addr[1:0] with wdata[7:0].
//     SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0]. SW writes all four lanes.
//     Unselected lanes are unchanged. rsp_rdata=0.
//   Loads: select a byte/half by addr[1:0]. B/H are sign-extended from bit 7/15.
//     BU/HU are zero-extended. W is passed through.
//   Inputs are sampled only at the accept edge; changes while busy are ignored.
//   Reset mid-operation returns to IDLE and drops the response.
//     A store still in WAIT with cnt!=0 is never committed.
//     A store already committed (state RESP) stays in the array.
//   Simultaneous rsp_ready and new req_valid in RESP: only the response completes.
//     The request is accepted no earlier than the next IDLE cycle.
// TESTING
//   1. SW addr 0x00010 data 0xDEADBEEF, then LW 0x00010 -> rsp_rdata=0xDEADBEEF, rsp_err=0.
//      rsp_valid rises 3 cycles after each accept (WAIT_CYCLES=2).
//   2. After test 1: SB 0x00011 data 0x80; LB 0x00011 -> 0xFFFFFF80; LBU 0x00011 -> 0x00000080.
//      LW 0x00010 -> 0xDEAD80EF.
//   3. SH 0x00012 data 0x1234, then LH 0x00013 -> rsp_err=1, rsp_rdata=0.
//      Then LHU 0x00012 -> 0x00001234, and the word at 0x00010 still has its other lanes intact.
//   4. LW 0x01000 (index 1024, DEPTH_WORDS=1024) -> rsp_err=1, no array change.
//      Store funct3=100 -> rsp_err=1.
//   5. Hold rsp_ready=0 for 5 cycles in RESP with req_valid=1 -> rsp_valid/rsp_rdata stable
//      and req_ready=0. On release, one handshake occurs, then req_ready=1 the next cycle.
//   6. Assert reset during WAIT of SW 0x00020 data 0xA5A5A5A5 (cnt=1) -> next cycle IDLE and
//      rsp_valid=0. A later LW 0x00020 returns the prior contents.

Source files
------------

// File: rtl/dmem_responder_if.sv
// ============================================================================
// Module      : dmem_responder_if
// Description : Load/store port handshake bundle between core and data memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_responder_if #(
  parameter int ADDR_W = 20
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        req_funct;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_funct, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_funct, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// Module      : dmem_responder
// Description : Handshaked multi-cycle data memory with byte-lane stores,
//               extended loads and an error flag for illegal accesses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder #(
  parameter int ADDR_W      = 20,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic           clk,
  input  logic           reset,
  dmem_responder_if.slave bus
);

  localparam int          c_idxW  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int          c_cntW  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [31:0] c_depth = DEPTH_WORDS;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [c_cntW-1:0]   r_cnt;
  logic                r_write;
  logic [2:0]          r_funct;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [31:0]         r_rdata;
  logic                r_err;
  logic [31:0]         r_mem [DEPTH_WORDS];

  logic                w_accept;
  logic                w_access;
  logic                w_funcLegal;
  logic                w_misaligned;
  logic                w_outOfRange;
  logic                w_err;
  logic [c_idxW-1:0]   w_idx;
  logic [31:0]         w_word;
  logic [3:0]          w_byteEn;
  logic [31:0]         w_laneData;
  logic [31:0]         w_shifted;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [31:0]         w_loadData;

  assign w_accept = bus.req_valid && bus.req_ready;
  assign w_access = (r_state == ST_WAIT) && (r_cnt == '0);

  // Zero-extended word index so the range test works for any DEPTH_WORDS.
  assign w_outOfRange = 32'(r_addr[ADDR_W-1:2]) >= c_depth;
  assign w_misaligned = ((r_funct[1:0] == 2'b01) && r_addr[0]) ||
                        ((r_funct[1:0] == 2'b10) && (r_addr[1:0] != 2'b00));
  assign w_err        = !w_funcLegal || w_misaligned || w_outOfRange;

  assign w_idx     = r_addr[c_idxW+1:2];
  assign w_word    = r_mem[w_idx];
  assign w_shifted = w_word >> {r_addr[1:0], 3'b000};
  assign w_byte    = w_shifted[7:0];
  assign w_half    = r_addr[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_funcLegal = 1'b0;
    case (r_funct)
      3'b000, 3'b001, 3'b010: w_funcLegal = 1'b1;
      3'b100, 3'b101:         w_funcLegal = !r_write;
      default:                w_funcLegal = 1'b0;
    endcase
  end

  always_comb begin
    w_byteEn   = 4'b1111;
    w_laneData = r_wdata;
    case (r_funct[1:0])
      2'b00: begin
        w_byteEn   = 4'b0001 << r_addr[1:0];
        w_laneData = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_byteEn   = r_addr[1] ? 4'b1100 : 4'b0011;
        w_laneData = {2{r_wdata[15:0]}};
      end
      default: begin
        w_byteEn   = 4'b1111;
        w_laneData = r_wdata;
      end
    endcase
  end

  always_comb begin
    w_loadData = 32'h0;
    case (r_funct)
      3'b000:  w_loadData = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_loadData = {{16{w_half[15]}}, w_half};
      3'b010:  w_loadData = w_word;
      3'b100:  w_loadData = {24'h0, w_byte};
      3'b101:  w_loadData = {16'h0, w_half};
      default: w_loadData = 32'h0;
    endcase
  end

  always_comb begin
    w_nextState   = r_state;
    bus.req_ready = (r_state == ST_IDLE) && !reset;
    bus.rsp_valid = (r_state == ST_RESP);
    bus.rsp_rdata = r_rdata;
    bus.rsp_err   = r_err;
    case (r_state)
      ST_IDLE: if (w_accept)      w_nextState = ST_WAIT;
      ST_WAIT: if (r_cnt == '0)   w_nextState = ST_RESP;
      ST_RESP: if (bus.rsp_ready) w_nextState = ST_IDLE;
      default:                    w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        r_cnt <= c_cntW'(WAIT_CYCLES);
      end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_access) begin
        r_err   <= w_err;
        r_rdata <= (w_err || r_write) ? 32'h0 : w_loadData;
      end
    end
  end

  // Request fields only matter once accepted, so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_write <= bus.req_write;
      r_funct <= bus.req_funct;
      r_addr  <= bus.req_addr;
      r_wdata <= bus.req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (w_access && !reset && r_write && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_byteEn[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_laneData[8*b +: 8];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// Module      : tb_dmem_responder
// Description : Randomized bench for dmem_responder against a byte-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_responder;

  localparam int ADDR_W      = 20;
  localparam int DEPTH_WORDS = 1024;
  localparam int WAIT_CYCLES = 2;

  logic clk = 1'b0;
  logic reset;
  int   nChecks = 0;
  int   nErrors = 0;
  logic [7:0] refMem [DEPTH_WORDS*4];

  dmem_responder_if #(.ADDR_W(ADDR_W)) bus ();

  dmem_responder #(
    .ADDR_W     (ADDR_W),
    .DEPTH_WORDS(DEPTH_WORDS),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Byte-addressed model: size/sign from funct3, then plain loops over bytes.
  function automatic void refAccess(input logic wr, input logic [2:0] f, input logic [19:0] a,
                                    input logic [31:0] wd, output logic err, output logic [31:0] rd);
    int   size  = 1;
    logic legal = 1'b0;
    logic sgn   = 1'b0;
    logic [31:0] val = 32'h0;
    case (f)
      3'd0: begin size = 1; legal = 1'b1; sgn = 1'b1; end
      3'd1: begin size = 2; legal = 1'b1; sgn = 1'b1; end
      3'd2: begin size = 4; legal = 1'b1; end
      3'd4: begin size = 1; legal = !wr; end
      3'd5: begin size = 2; legal = !wr; end
      default: legal = 1'b0;
    endcase
    err = !legal || (int'(a) % size != 0) || (int'(a) / 4 >= DEPTH_WORDS);
    rd  = 32'h0;
    if (!err) begin
      if (wr) begin
        for (int i = 0; i < size; i++) refMem[int'(a) + i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < size; i++) val = val | (32'(refMem[int'(a) + i]) << (8*i));
        if (sgn && size < 4 && val[8*size-1]) val = val | (32'hFFFF_FFFF << (8*size));
        rd = val;
      end
    end
  endfunction

  task automatic doTxn(input logic wr, input logic [2:0] f, input logic [19:0] a,
                       input logic [31:0] wd, input int hold,
                       output logic [31:0] rd, output logic err);
    logic [31:0] expRd;
    logic        expErr;
    int          lat;
    int          guard;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_funct = f;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    bus.rsp_ready = 1'b0;
    guard = 0;
    while (!bus.req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkVal("acceptReady", 32'(bus.req_ready), 32'd1);
    refAccess(wr, f, a, wd, expErr, expRd);
    @(posedge clk);
    @(negedge clk);
    // Busy-time input changes must be ignored.
    bus.req_valid = 1'b0;
    bus.req_write = 1'($urandom);
    bus.req_funct = 3'($urandom);
    bus.req_addr  = 20'($urandom);
    bus.req_wdata = $urandom;
    lat = 0;
    while (!bus.rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkVal("latency", 32'(lat), 32'(WAIT_CYCLES + 1));
    rd  = bus.rsp_rdata;
    err = bus.rsp_err;
    checkVal("rdata", rd, expRd);
    checkVal("err", 32'(err), 32'(expErr));
    for (int h = 0; h < hold; h++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = 20'($urandom);
      @(negedge clk);
      checkVal("holdValid", 32'(bus.rsp_valid), 32'd1);
      checkVal("holdRdata", bus.rsp_rdata, rd);
      checkVal("holdErr", 32'(bus.rsp_err), 32'(err));
      checkVal("holdReqReady", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b0;
    checkVal("rspDrop", 32'(bus.rsp_valid), 32'd0);
    checkVal("readyAfter", 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;
    logic [31:0] prior;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_funct = 3'd0;
    bus.req_addr  = '0;
    bus.req_wdata = 32'h0;
    bus.rsp_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkVal("rstReqReady", 32'(bus.req_ready), 32'd0);
    checkVal("rstRspValid", 32'(bus.rsp_valid), 32'd0);
    checkVal("rstRdata", bus.rsp_rdata, 32'h0);
    checkVal("rstErr", 32'(bus.rsp_err), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    checkVal("postRstReady", 32'(bus.req_ready), 32'd1);

    // The array powers up unknown; give the exercised region defined contents.
    for (int w = 0; w < 64; w++) doTxn(1'b1, 3'd2, 20'(w*4), $urandom, 0, rd, err);

    doTxn(1'b1, 3'd2, 20'h00010, 32'hDEADBEEF, 0, rd, err);
    doTxn(1'b0, 3'd2, 20'h00010, 32'h0, 0, rd, err);
    checkVal("t1Lw", rd, 32'hDEADBEEF);
    checkVal("t1Err", 32'(err), 32'd0);

    doTxn(1'b1, 3'd0, 20'h00011, 32'h00000080, 0, rd, err);
    doTxn(1'b0, 3'd0, 20'h00011, 32'h0, 0, rd, err);
    checkVal("t2Lb", rd, 32'hFFFFFF80);
    doTxn(1'b0, 3'd4, 20'h00011, 32'h0, 0, rd, err);
    checkVal("t2Lbu", rd, 32'h00000080);
    doTxn(1'b0, 3'd2, 20'h00010, 32'h0, 0, rd, err);
    checkVal("t2Lw", rd, 32'hDEAD80EF);

    doTxn(1'b1, 3'd1, 20'h00012, 32'h00001234, 0, rd, err);
    doTxn(1'b0, 3'd1, 20'h00013, 32'h0, 0, rd, err);
    checkVal("t3MisErr", 32'(err), 32'd1);
    checkVal("t3MisData", rd, 32'h0);
    doTxn(1'b0, 3'd5, 20'h00012, 32'h0, 0, rd, err);
    checkVal("t3Lhu", rd, 32'h00001234);
    doTxn(1'b0, 3'd2, 20'h00010, 32'h0, 0, rd, err);
    checkVal("t3Lw", rd, 32'h123480EF);

    doTxn(1'b0, 3'd2, 20'h01000, 32'h0, 0, rd, err);
    checkVal("t4RangeErr", 32'(err), 32'd1);
    doTxn(1'b1, 3'd4, 20'h00010, 32'h55555555, 0, rd, err);
    checkVal("t4StBuErr", 32'(err), 32'd1);
    doTxn(1'b0, 3'd2, 20'h00010, 32'h0, 0, rd, err);
    checkVal("t4NoChange", rd, 32'h123480EF);

    doTxn(1'b0, 3'd2, 20'h00010, 32'h0, 5, rd, err);
    checkVal("t5Lw", rd, 32'h123480EF);

    prior = {refMem[35], refMem[34], refMem[33], refMem[32]};
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_funct = 3'd2;
    bus.req_addr  = 20'h00020;
    bus.req_wdata = 32'hA5A5A5A5;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkVal("t6RspValid", 32'(bus.rsp_valid), 32'd0);
    checkVal("t6ReadyInRst", 32'(bus.req_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    checkVal("t6ReadyIdle", 32'(bus.req_ready), 32'd1);
    doTxn(1'b0, 3'd2, 20'h00020, 32'h0, 0, rd, err);
    checkVal("t6Prior", rd, prior);

    for (int n = 0; n < 150; n++) begin
      logic [19:0] a;
      if ($urandom_range(0, 9) == 0) a = 20'($urandom_range(32'h1000, 32'hFFFFF));
      else                           a = 20'($urandom_range(0, 255));
      doTxn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
            int'($urandom_range(0, 3)), rd, err);
    end

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule

`default_nettype wire
